wave_generator: RTL and testbench
=================================

Name: wave_generator

Overview:
Parametrised successor to the basic triangle counter. Produces triangle, sawtooth-up, sawtooth-down or square waveforms. Each waveform runs between programmable bounds lo..hi with a programmable step. Sits between a control/config register block and the PWM/DAC output stage. Also emits a one-cycle period-complete strobe used to sync downstream logic.

Parameters:
N, 8, output/bound/step width in bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ena  in  1  advance waveform by one step when high; hold otherwise
cfg_load  in  1  capture mode/lo/hi/step and restart waveform
cfg_mode  in  2  mode_t: TRIANGLE, SAW_UP, SAW_DOWN, SQUARE
cfg_lo  in  N  lower bound (inclusive)
cfg_hi  in  N  upper bound (inclusive)
cfg_step  in  N  increment magnitude; 0 treated as 1
out  out  N  waveform value
dir_up  out  1  1 while internal counter is ascending
period  out  1  one-cycle strobe at end of each waveform period

Behaviour:
- Reset: count=0, lo=0, hi={N{1'b1}}, step=1, mode=TRIANGLE, dir_up=1, period=0, out=0. Post-reset behaviour equals the legacy 0..2^N-1..0 triangle.
- Registered state: count, dir_up, period, and shadow regs mode/lo/hi/step. All outputs derive from registers only, with no comb path from inputs.
- out = count for TRIANGLE/SAW_*. For SQUARE, out = dir_up ? hi : lo.
- Priority per clk edge: rst > cfg_load > ena > hold.
- cfg_load: shadows <= cfg_*. count <= (cfg_mode==SAW_DOWN) ? cfg_hi : cfg_lo. dir_up <= (cfg_mode!=SAW_DOWN). period <= 0. ena is ignored that cycle.
- Next-value arithmetic is done in N+1 bits so there is no silent overflow/underflow.
- Up: sum = count+step. If sum >= hi, then count <= hi.
- Down: diff = count-step (signed N+1). If diff <= lo, then count <= lo.
- TRIANGLE and SQUARE when ena:
  - up: if sum >= hi, count <= hi and dir_up <= 0; else count <= sum.
  - down: if diff <= lo, count <= lo, dir_up <= 1, period <= 1; else count <= diff.
  - Endpoints appear exactly once per turn.
- SAW_UP when ena: if sum > hi, count <= lo and period <= 1; else count <= sum. dir_up stays 1.
- SAW_DOWN when ena: if diff < lo, count <= hi and period <= 1; else count <= diff. dir_up stays 0.
- period is high only in the cycle after the wrapping/turning edge. It is cleared on any cycle without that event, including ena=0.
- Degenerate bounds lo >= hi: count holds lo, dir_up holds, period is never asserted.
- Bounds outside a reachable step grid are legal; clamping handles them.
- rst mid-period: full defaults restored on the next edge, shadows included.

Decomposition:
- Package wave_gen_pkg:
  - mode_t enum (TRIANGLE=2'b00, SAW_UP=2'b01, SAW_DOWN=2'b10, SQUARE=2'b11).
  - dir_t (DIR_DOWN=0, DIR_UP=1).
- Combinational sub-module wave_step (parameter N):
  - inputs: count, step, lo, hi, dir_up, mode.
  - outputs: next_count, next_dir_up, wrap_event.
  - Contains all N+1-bit clamp/wrap arithmetic.
- Top: registers, cfg priority, period strobe, output mux.

Test Plan:
- N=4, reset then ena=1 for 32 cycles -> out 0,1..15,14..0,1,…; dir_up falls after 15. period high exactly one cycle, in the cycle out first returns to 0 (the 31st sample).
- cfg_load TRIANGLE lo=2 hi=9 step=3, ena=1 -> out 2,5,8,9,6,3,2,5. period high only with the second 2.
- cfg_load SAW_UP lo=2 hi=9 step=3 -> out 2,5,8,2,5. period high with the returning 2. Repeat with SAW_DOWN -> 9,6,3,9, period with the returning 9.
- SQUARE lo=1 hi=6 step=2, then toggle ena 1,0,1 mid-run -> out holds value (6 while rising, 1 while falling) during ena=0. Transitions match the triangle sequence 1,3,5,6,4,2,1.
- lo=hi=5 and separately step=0 -> first case out constant 5 with no period; second case behaves identically to step=1.
- rst asserted mid SAW_UP run with cfg_load high the same cycle -> next cycle out=0, dir_up=1, period=0. Legacy triangle resumes.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types for the wave generator: waveform mode and counter direction encodings.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        TRIANGLE = 2'b00,
        SAW_UP   = 2'b01,
        SAW_DOWN = 2'b10,
        SQUARE   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/wave_step.sv
// Next-state arithmetic for the wave counter: clamping at turn points and wrapping for sawtooth modes.
module wave_step
    import wave_gen_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] step,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    input  logic         dir_up,
    input  mode_t        mode,
    output logic [N-1:0] next_count,
    output logic         next_dir_up,
    output logic         wrap_event
);

    logic [N-1:0]        step_eff;
    logic [N:0]          sum;
    logic signed [N:0]   diff;
    logic signed [N:0]   lo_s;
    logic [N:0]          hi_x;

    // A zero step would stall the counter forever, so it advances by one instead.
    assign step_eff = (step == '0) ? N'(1) : step;
    assign sum      = {1'b0, count} + {1'b0, step_eff};
    assign diff     = $signed({1'b0, count}) - $signed({1'b0, step_eff});
    assign lo_s     = $signed({1'b0, lo});
    assign hi_x     = {1'b0, hi};

    always_comb begin
        next_count  = count;
        next_dir_up = dir_up;
        wrap_event  = 1'b0;
        if (lo >= hi) begin
            next_count = lo;
        end else begin
            case (mode)
                TRIANGLE, SQUARE: begin
                    if (dir_up) begin
                        if (sum >= hi_x) begin
                            next_count  = hi;
                            next_dir_up = DIR_DOWN;
                        end else begin
                            next_count = sum[N-1:0];
                        end
                    end else begin
                        if (diff <= lo_s) begin
                            next_count  = lo;
                            next_dir_up = DIR_UP;
                            wrap_event  = 1'b1;
                        end else begin
                            next_count = diff[N-1:0];
                        end
                    end
                end
                SAW_UP: begin
                    next_dir_up = DIR_UP;
                    if (sum > hi_x) begin
                        next_count = lo;
                        wrap_event = 1'b1;
                    end else begin
                        next_count = sum[N-1:0];
                    end
                end
                SAW_DOWN: begin
                    next_dir_up = DIR_DOWN;
                    if (diff < lo_s) begin
                        next_count = hi;
                        wrap_event = 1'b1;
                    end else begin
                        next_count = diff[N-1:0];
                    end
                end
                default: begin
                    next_count = count;
                end
            endcase
        end
    end

endmodule

// File: rtl/wave_generator.sv
// Programmable triangle/sawtooth/square generator with shadowed bounds and a period-complete strobe.
module wave_generator
    import wave_gen_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         cfg_load,
    input  logic [1:0]   cfg_mode,
    input  logic [N-1:0] cfg_lo,
    input  logic [N-1:0] cfg_hi,
    input  logic [N-1:0] cfg_step,
    output logic [N-1:0] out,
    output logic         dir_up,
    output logic         period
);

    mode_t        mode_q;
    logic [N-1:0] lo_q;
    logic [N-1:0] hi_q;
    logic [N-1:0] step_q;
    logic [N-1:0] count_q;
    logic         dir_up_q;
    logic         period_q;

    logic [N-1:0] next_count;
    logic         next_dir_up;
    logic         wrap_event;
    mode_t        cfg_mode_e;

    assign cfg_mode_e = mode_t'(cfg_mode);

    wave_step #(
        .N (N)
    ) u_step (
        .count       (count_q),
        .step        (step_q),
        .lo          (lo_q),
        .hi          (hi_q),
        .dir_up      (dir_up_q),
        .mode        (mode_q),
        .next_count  (next_count),
        .next_dir_up (next_dir_up),
        .wrap_event  (wrap_event)
    );

    // Defaults reproduce the legacy full-range triangle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= TRIANGLE;
            lo_q     <= '0;
            hi_q     <= '1;
            step_q   <= N'(1);
            count_q  <= '0;
            dir_up_q <= DIR_UP;
            period_q <= 1'b0;
        end else if (cfg_load) begin
            mode_q   <= cfg_mode_e;
            lo_q     <= cfg_lo;
            hi_q     <= cfg_hi;
            step_q   <= cfg_step;
            count_q  <= (cfg_mode_e == SAW_DOWN) ? cfg_hi : cfg_lo;
            dir_up_q <= (cfg_mode_e != SAW_DOWN);
            period_q <= 1'b0;
        end else if (ena) begin
            count_q  <= next_count;
            dir_up_q <= next_dir_up;
            period_q <= wrap_event;
        end else begin
            period_q <= 1'b0;
        end
    end

    assign out    = (mode_q == SQUARE) ? (dir_up_q ? hi_q : lo_q) : count_q;
    assign dir_up = dir_up_q;
    assign period = period_q;

endmodule

// File: tb/tb_wave_generator.sv
// Self-checking bench for wave_generator (N=4): behavioural model feeds a scoreboard, plus directed sequence checks.
module tb_wave_generator;
    import wave_gen_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         cfg_load;
    logic [1:0]   cfg_mode;
    logic [N-1:0] cfg_lo;
    logic [N-1:0] cfg_hi;
    logic [N-1:0] cfg_step;
    logic [N-1:0] out;
    logic         dir_up;
    logic         period;

    wave_generator #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .cfg_load (cfg_load),
        .cfg_mode (cfg_mode),
        .cfg_lo   (cfg_lo),
        .cfg_hi   (cfg_hi),
        .cfg_step (cfg_step),
        .out      (out),
        .dir_up   (dir_up),
        .period   (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int out_v;
        int dir_v;
        int per_v;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "reset";

    int m_count, m_dir, m_period, m_mode, m_lo, m_hi, m_step;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", phase, tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit e,
                              input int md, input int lo_i, input int hi_i, input int st_i);
        int s;
        if (r) begin
            m_count = 0; m_dir = 1; m_period = 0;
            m_mode = 0; m_lo = 0; m_hi = (1 << N) - 1; m_step = 1;
        end else if (l) begin
            m_mode = md; m_lo = lo_i; m_hi = hi_i; m_step = st_i;
            m_count = (md == 2) ? hi_i : lo_i;
            m_dir = (md != 2) ? 1 : 0;
            m_period = 0;
        end else if (e) begin
            s = (m_step == 0) ? 1 : m_step;
            m_period = 0;
            if (m_lo >= m_hi) begin
                m_count = m_lo;
            end else if (m_mode == 0 || m_mode == 3) begin
                if (m_dir == 1) begin
                    if (m_count + s >= m_hi) begin m_count = m_hi; m_dir = 0; end
                    else m_count = m_count + s;
                end else begin
                    if (m_count - s <= m_lo) begin m_count = m_lo; m_dir = 1; m_period = 1; end
                    else m_count = m_count - s;
                end
            end else if (m_mode == 1) begin
                m_dir = 1;
                if (m_count + s > m_hi) begin m_count = m_lo; m_period = 1; end
                else m_count = m_count + s;
            end else begin
                m_dir = 0;
                if (m_count - s < m_lo) begin m_count = m_hi; m_period = 1; end
                else m_count = m_count - s;
            end
        end else begin
            m_period = 0;
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge.
    task automatic cyc(input bit r, input bit l, input bit e,
                       input int md, input int lo_i, input int hi_i, input int st_i);
        exp_t x;
        exp_t got;
        rst      = r;
        cfg_load = l;
        ena      = e;
        cfg_mode = 2'(md);
        cfg_lo   = N'(lo_i);
        cfg_hi   = N'(hi_i);
        cfg_step = N'(st_i);
        model_step(r, l, e, md, lo_i, hi_i, st_i);
        x.out_v = (m_mode == 3) ? ((m_dir == 1) ? m_hi : m_lo) : m_count;
        x.dir_v = m_dir;
        x.per_v = m_period;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_val("out", int'(out), got.out_v);
        check_val("dir_up", int'(dir_up), got.dir_v);
        check_val("period", int'(period), got.per_v);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(0, 0, e, 0, 0, 0, 0);
    endtask

    int tri_exp[8] = '{2, 5, 8, 9, 6, 3, 2, 5};
    int sq_ena[10] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};

    initial begin
        int pcount;
        int ppos;

        rst = 1'b1; ena = 1'b0; cfg_load = 1'b0;
        cfg_mode = '0; cfg_lo = '0; cfg_hi = '0; cfg_step = '0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        check_val("reset_out", int'(out), 0);

        phase = "legacy";
        pcount = 0; ppos = -1;
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            if (i == 14) check_val("peak", int'(out), 15);
            if (period) begin pcount++; ppos = i; end
        end
        check_val("period_count", pcount, 1);
        check_val("period_pos", ppos, 29);

        phase = "tri_2_9_3";
        cyc(0, 1, 1, 0, 2, 9, 3);
        check_val("seq0", int'(out), tri_exp[0]);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            check_val("seq", int'(out), tri_exp[i]);
        end

        phase = "saw_up";
        cyc(0, 1, 0, 1, 2, 9, 3);
        run(6, 1);
        phase = "saw_down";
        cyc(0, 1, 0, 2, 2, 9, 3);
        run(6, 1);

        phase = "square";
        cyc(0, 1, 0, 3, 1, 6, 2);
        for (int i = 0; i < 10; i++) cyc(0, 0, sq_ena[i] != 0, 0, 0, 0, 0);
        run(4, 1);

        phase = "degenerate";
        cyc(0, 1, 0, 0, 5, 5, 2);
        run(5, 1);
        check_val("flat", int'(out), 5);
        cyc(0, 1, 0, 1, 5, 5, 1);
        run(3, 1);
        cyc(0, 1, 0, 2, 9, 3, 1);
        run(3, 1);

        phase = "step0";
        cyc(0, 1, 0, 0, 0, 15, 0);
        run(34, 1);

        phase = "offgrid";
        cyc(0, 1, 0, 0, 3, 14, 4);
        run(10, 1);
        cyc(0, 1, 0, 1, 3, 14, 4);
        run(6, 1);
        cyc(0, 1, 0, 2, 3, 14, 4);
        run(6, 1);
        cyc(0, 1, 0, 1, 0, 15, 15);
        run(4, 1);

        phase = "hold";
        cyc(0, 1, 0, 0, 0, 12, 6);
        run(3, 1);
        run(3, 0);
        run(3, 1);

        phase = "rst_mid";
        cyc(0, 1, 0, 1, 2, 9, 3);
        run(3, 1);
        cyc(1, 1, 1, 2, 7, 12, 2);
        check_val("rst_out", int'(out), 0);
        run(6, 1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
